// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive front end: FSM encodings and default frame geometry.
// Parity support in rx_frame_ctrl is compiled in only when RX_PARITY_EN is defined.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  localparam int unsigned DATA_BITS_D  = 8;
  localparam int unsigned OVERSAMPLE_D = 16;

  // 0 selects even parity, 1 selects odd parity.
  localparam logic PARITY_ODD = 1'b0;

endpackage

// File: rtl/rx_sync.sv
// Multi-flop synchronizer for the asynchronous serial line.
// Resets to 1 so that reset looks like an idle line rather than a start edge.
module rx_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_STAGES-1:0] sync_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/rx_frame_ctrl.sv
// UART receive framer: start-bit search, LSB-first data capture and stop-bit hand-off.
// Define RX_PARITY_EN to add a parity bit before the stop bit and the parity_error output.
module rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS   = DATA_BITS_D,
  parameter int unsigned OVERSAMPLE  = OVERSAMPLE_D,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  output logic [DATA_BITS-1:0] sipo_out,
  output logic                 stop_bit_in,
  output logic                 chk_stop,
  output logic                 busy,
`ifdef RX_PARITY_EN
  output logic                 parity_error,
`endif
  output logic                 start_glitch
);

  localparam int unsigned TickW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW  = $clog2(DATA_BITS + 1);

  localparam logic [TickW-1:0] TickMid  = TickW'(OVERSAMPLE / 2 - 1);
  localparam logic [TickW-1:0] TickLast = TickW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0]  BitLast  = BitW'(DATA_BITS - 1);

  logic                 rx_s;
  rx_state_e            state_q;
  logic [TickW-1:0]     tick_cnt_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [DATA_BITS-1:0] sipo_q;
  logic                 stop_bit_q;
  logic                 chk_stop_q;
  logic                 busy_q;
  logic                 start_glitch_q;
`ifdef RX_PARITY_EN
  logic                 parity_q;
  logic                 parity_error_q;
`endif

  rx_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (rx_in),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= ST_IDLE;
      tick_cnt_q     <= '0;
      bit_cnt_q      <= '0;
      shift_q        <= '0;
      sipo_q         <= '0;
      stop_bit_q     <= 1'b1;
      chk_stop_q     <= 1'b0;
      busy_q         <= 1'b0;
      start_glitch_q <= 1'b0;
`ifdef RX_PARITY_EN
      parity_q       <= 1'b0;
      parity_error_q <= 1'b0;
`endif
    end else begin
      chk_stop_q     <= 1'b0;
      start_glitch_q <= 1'b0;
      if (baud_tick) begin
        case (state_q)
          ST_IDLE: begin
            if (!rx_s) begin
              tick_cnt_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= ST_START;
            end
          end
          ST_START: begin
            if (tick_cnt_q == TickMid) begin
              if (!rx_s) begin
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
                state_q    <= ST_DATA;
              end else begin
                start_glitch_q <= 1'b1;
                busy_q         <= 1'b0;
                state_q        <= ST_IDLE;
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          ST_DATA: begin
            // Counting restarted at the start-bit centre, so wrap points land on bit centres.
            if (tick_cnt_q == TickLast) begin
              tick_cnt_q <= '0;
              shift_q    <= {rx_s, shift_q[DATA_BITS-1:1]};
              bit_cnt_q  <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == BitLast) begin
`ifdef RX_PARITY_EN
                state_q <= ST_PARITY;
`else
                state_q <= ST_STOP;
`endif
              end
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
`ifdef RX_PARITY_EN
          ST_PARITY: begin
            if (tick_cnt_q == TickLast) begin
              tick_cnt_q <= '0;
              parity_q   <= rx_s;
              state_q    <= ST_STOP;
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
`endif
          ST_STOP: begin
            // Returning to idle at the stop-bit centre leaves half a bit to catch a
            // back-to-back start edge. A low stop bit is passed on as-is.
            if (tick_cnt_q == TickLast) begin
              tick_cnt_q <= '0;
              sipo_q     <= shift_q;
              stop_bit_q <= rx_s;
              chk_stop_q <= 1'b1;
              busy_q     <= 1'b0;
              state_q    <= ST_IDLE;
`ifdef RX_PARITY_EN
              parity_error_q <= (^{shift_q, parity_q}) ^ PARITY_ODD;
`endif
            end else begin
              tick_cnt_q <= tick_cnt_q + 1'b1;
            end
          end
          default: begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        endcase
      end
    end
  end

  assign sipo_out     = sipo_q;
  assign stop_bit_in  = stop_bit_q;
  assign chk_stop     = chk_stop_q;
  assign busy         = busy_q;
  assign start_glitch = start_glitch_q;
`ifdef RX_PARITY_EN
  assign parity_error = parity_error_q;
`endif

endmodule
